// File: rtl/fxp_pe_array_nxn.sv
// rtl/fxp_pe_array_nxn.sv - sign-magnitude fixed-point NxN matrix-multiply engine
// Loads A and B row-major, runs N MAC cycles on an output-stationary grid, drains C row-major.
module fxp_pe_array_nxn #(
  parameter int N     = 3,
  parameter int W     = 8,
  parameter int FRAC  = 3,
  parameter int ACC_W = 2*W + $clog2(N)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en_in_data,
  output logic         rdy_in_data,
  input  logic         in_mat,
  input  logic         in_new_row,
  input  logic         in_mat_done,
  input  logic         in_acc,
  input  logic [W-1:0] in_data,
  output logic         en_out_data,
  input  logic         rdy_out_data,
  output logic         out_new_row,
  output logic         out_mat_done,
  output logic         out_sat,
  output logic [W-1:0] out_data
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N-1);
  localparam logic [ACC_W-1:0] MAG_MAX = ACC_W'((1 << (W-1)) - 1);

  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            r_q, r_d, c_q, c_d, k_q, k_d;
  logic [CW-1:0]            orow_q, orow_d, ocol_q, ocol_d;
  logic                     loaded_a_q, loaded_a_d, loaded_b_q, loaded_b_d;
  logic                     live_q, live_d;
  logic [W-1:0]             a_q [N][N], a_d [N][N];
  logic [W-1:0]             b_q [N][N], b_d [N][N];
  logic signed [ACC_W-1:0]  acc_q [N][N], acc_d [N][N];

  logic                     wr;
  logic [W-1:0]             wdata;
  logic signed [2*W-1:0]    prod;
  logic signed [ACC_W-1:0]  sel;
  logic [ACC_W-1:0]         mag, mag_sh;
  logic                     sat;
  logic [W-2:0]             omag;
  logic                     drain;

  function automatic logic signed [W-1:0] sm2tc(input logic [W-1:0] x);
    logic signed [W-1:0] m;
    m = signed'({1'b0, x[W-2:0]});
    return x[W-1] ? -m : m;
  endfunction

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    k_d         = k_q;
    orow_d      = orow_q;
    ocol_d      = ocol_q;
    loaded_a_d  = loaded_a_q;
    loaded_b_d  = loaded_b_q;
    live_d      = 1'b1;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    wr          = 1'b0;
    wdata       = in_data;
    prod        = '0;
    rdy_in_data = 1'b0;

    case (state_q)
      LOAD: begin
        if (loaded_a_q && loaded_b_q) begin
          state_d = COMPUTE;
        end else if (live_q && en_in_data && !(in_mat ? loaded_b_q : loaded_a_q)) begin
          wr = 1'b1;
          // Pad beats write zero and hold the beat until its own slot is reached
          if (in_mat_done) begin
            wdata       = '0;
            rdy_in_data = (r_q == LAST) && (c_q == LAST);
          end else if (in_new_row && (c_q != '0)) begin
            wdata = '0;
          end else begin
            rdy_in_data = 1'b1;
          end
        end
      end
      COMPUTE: begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            prod = (2*W)'(sm2tc(a_q[i][k_q])) * (2*W)'(sm2tc(b_q[k_q][j]));
            acc_d[i][j] = acc_q[i][j] + ACC_W'(prod);
          end
        end
        if (k_q == LAST) begin
          k_d = '0;
          if (in_acc) begin
            state_d    = LOAD;
            loaded_a_d = 1'b0;
            loaded_b_d = 1'b0;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        if (rdy_out_data) begin
          if (ocol_q == LAST) begin
            ocol_d = '0;
            if (orow_q == LAST) begin
              orow_d     = '0;
              state_d    = LOAD;
              loaded_a_d = 1'b0;
              loaded_b_d = 1'b0;
              for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                  acc_d[i][j] = '0;
            end else begin
              orow_d = orow_q + 1'b1;
            end
          end else begin
            ocol_d = ocol_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase

    if (wr) begin
      if (in_mat) b_d[r_q][c_q] = wdata;
      else        a_d[r_q][c_q] = wdata;
      if (c_q == LAST) begin
        c_d = '0;
        if (r_q == LAST) begin
          r_d = '0;
          if (in_mat) loaded_b_d = 1'b1;
          else        loaded_a_d = 1'b1;
        end else begin
          r_d = r_q + 1'b1;
        end
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  // Accumulator to sign-magnitude: truncate magnitude, saturate, fold -0 to +0
  always_comb begin
    sel    = acc_q[orow_q][ocol_q];
    mag    = sel[ACC_W-1] ? $unsigned(-sel) : $unsigned(sel);
    mag_sh = mag >> FRAC;
    sat    = mag_sh > MAG_MAX;
    omag   = sat ? {(W-1){1'b1}} : mag_sh[W-2:0];
    drain  = (state_q == DRAIN);
    en_out_data  = drain;
    out_new_row  = drain && (ocol_q == '0);
    out_mat_done = drain && (orow_q == LAST) && (ocol_q == LAST);
    out_sat      = drain && sat;
    out_data     = drain ? {sel[ACC_W-1] && (omag != '0), omag} : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= LOAD;
      r_q        <= '0;
      c_q        <= '0;
      k_q        <= '0;
      orow_q     <= '0;
      ocol_q     <= '0;
      loaded_a_q <= 1'b0;
      loaded_b_q <= 1'b0;
      live_q     <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_q[i][j]   <= '0;
          b_q[i][j]   <= '0;
          acc_q[i][j] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      c_q        <= c_d;
      k_q        <= k_d;
      orow_q     <= orow_d;
      ocol_q     <= ocol_d;
      loaded_a_q <= loaded_a_d;
      loaded_b_q <= loaded_b_d;
      live_q     <= live_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
    end
  end
endmodule
